// File: rtl/izh_pkg.sv
// Shared Izhikevich definitions: 8.9 fixed-point format, ISI width, serialiser states.
// Helpers are pure functions used by both the neuron core and the spike monitor.
package izh_pkg;

  localparam int FXP_W    = 18;
  localparam int FXP_FRAC = 9;
  localparam int ISI_W    = 16;

  typedef logic signed [FXP_W-1:0] fxp_t;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } ser_state_e;

  // Integer part of an 8.9 value (sign bit excluded, two's-complement byte).
  function automatic logic [7:0] fxp_int8(input fxp_t v);
    return v[FXP_FRAC+7:FXP_FRAC];
  endfunction

  function automatic fxp_t fxp_sat_add(input fxp_t a, input fxp_t b);
    logic signed [FXP_W:0] s;
    s = {a[FXP_W-1], a} + {b[FXP_W-1], b};
    if (s[FXP_W] != s[FXP_W-1])
      return s[FXP_W] ? {1'b1, {(FXP_W-1){1'b0}}} : {1'b0, {(FXP_W-1){1'b1}}};
    return s[FXP_W-1:0];
  endfunction

  function automatic fxp_t fxp_mul(input fxp_t a, input fxp_t b);
    logic signed [2*FXP_W-1:0] p;
    logic signed [2*FXP_W-1:0] sh;
    p  = a * b;
    sh = p >>> FXP_FRAC;
    if (sh > $signed({{(FXP_W+1){1'b0}}, {(FXP_W-1){1'b1}}}))
      return {1'b0, {(FXP_W-1){1'b1}}};
    if (sh < $signed({{(FXP_W+1){1'b1}}, {(FXP_W-1){1'b0}}}))
      return {1'b1, {(FXP_W-1){1'b0}}};
    return sh[FXP_W-1:0];
  endfunction

endpackage

// File: rtl/izh_spike_monitor_if.sv
// Neuron-step input and byte-stream output of the spike monitor.
// master = monitor side, slave = neuron core / byte consumer side.
interface izh_spike_monitor_if;
  import izh_pkg::*;

  logic       step_valid;
  logic       spike_in;
  fxp_t       v_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  step_valid, spike_in, v_in, out_ready,
    output out_data, out_valid
  );

  modport slave (
    output step_valid, spike_in, v_in, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/izh_isi_fifo.sv
// Synchronous ISI FIFO, registered pointers; a push is visible on rdata the next cycle.
// Push while full is ignored unless a pop happens in the same cycle.
module izh_isi_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/izh_spike_monitor.sv
// Measures inter-spike intervals, buffers them and streams each as two bytes (MSB first) on valid/ready.
// Build option: define SPIKE_RATE_EN to add the per-window spike-rate counter on rate_out.
module izh_spike_monitor
  import izh_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ISI_W       = 16,
  parameter int RATE_WINDOW = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  izh_spike_monitor_if.master mon,
  output logic                fifo_full,
  output logic                overflow,
  output logic [7:0]          rate_out
);

  if (ISI_W != izh_pkg::ISI_W || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      RATE_WINDOW < 1) begin : g_param_check
    $error("izh_spike_monitor: unsupported parameter set");
  end

  logic             step, spike;
  logic [ISI_W-1:0] isi_q, isi_d, isi_inc;
  logic [ISI_W-1:0] shadow_q, shadow_d, fifo_rdata;
  logic             fifo_empty, fifo_is_full, fifo_pop;
  ser_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;

  assign step  = ena & mon.step_valid;
  assign spike = step & mon.spike_in;

  // The pushed ISI includes the spike step itself, hence the increment before push.
  always_comb begin
    isi_inc = (isi_q == {ISI_W{1'b1}}) ? isi_q : isi_q + ISI_W'(1);
    isi_d   = isi_q;
    if (step) isi_d = mon.spike_in ? '0 : isi_inc;
  end

  izh_isi_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ISI_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (spike),
    .pop   (fifo_pop),
    .wdata (isi_inc),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_is_full)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    fifo_pop    = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shadow_d    = fifo_rdata;
            state_d     = HI;
            out_valid_d = 1'b1;
          end
        end
        HI: begin
          if (mon.out_ready) state_d = LO;
        end
        LO: begin
          if (mon.out_ready) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shadow_d = fifo_rdata;
              state_d  = HI;
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
    overflow_d = overflow_q | (spike & fifo_is_full & ~fifo_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_q       <= '0;
      state_q     <= IDLE;
      shadow_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      isi_q       <= isi_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign mon.out_valid = out_valid_q;
  assign mon.out_data  = !out_valid_q     ? fxp_int8(mon.v_in) :
                         (state_q == HI)  ? shadow_q[ISI_W-1:8] : shadow_q[7:0];
  assign fifo_full     = fifo_is_full;
  assign overflow      = overflow_q;

`ifdef SPIKE_RATE_EN
  localparam int                WIN_W    = $clog2(RATE_WINDOW + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(RATE_WINDOW - 1);

  logic [WIN_W-1:0] win_q, win_d;
  logic [7:0]       spk_q, spk_d, rate_q, rate_d, spk_sum;

  // Window close folds in a spike on the closing step itself.
  always_comb begin
    spk_sum = (!spike || spk_q == 8'hFF) ? spk_q : spk_q + 8'd1;
    win_d   = win_q;
    spk_d   = spk_q;
    rate_d  = rate_q;
    if (step) begin
      if (win_q == WIN_LAST) begin
        rate_d = spk_sum;
        win_d  = '0;
        spk_d  = '0;
      end else begin
        win_d = win_q + WIN_W'(1);
        spk_d = spk_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      spk_q  <= '0;
      rate_q <= '0;
    end else begin
      win_q  <= win_d;
      spk_q  <= spk_d;
      rate_q <= rate_d;
    end
  end

  assign rate_out = rate_q;
`else
  assign rate_out = 8'h00;
`endif

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Directed bench for izh_spike_monitor: ISI streaming, overflow, saturation, reset, enable, rate window.
module tb_izh_spike_monitor;
  import izh_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       fifo_full, overflow;
  logic [7:0] rate_out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  izh_spike_monitor_if bus();

  izh_spike_monitor #(
    .FIFO_DEPTH  (8),
    .ISI_W       (16),
    .RATE_WINDOW (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mon       (bus),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .rate_out  (rate_out)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    bus.step_valid = 1'b0;
    bus.spike_in   = 1'b0;
    bus.out_ready  = 1'b0;
    ena            = 1'b1;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // n consecutive steps; a spike on every spk_every-th step (0 = no spikes).
  task automatic run_steps(input int n, input int spk_every);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.step_valid = 1'b1;
      bus.spike_in   = (spk_every != 0) && (((i + 1) % spk_every) == 0);
    end
    @(posedge clk); #1;
    bus.step_valid = 1'b0;
    bus.spike_in   = 1'b0;
  endtask

  // Accepts up to n bytes with out_ready high, recording the cycle of each.
  task automatic drain(input int n, input int budget);
    int cyc;
    cyc = 0;
    rx_q.delete();
    rx_t.delete();
    bus.out_ready = 1'b1;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        rx_q.push_back(bus.out_data);
        rx_t.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL drain_count got %0d bytes want %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.v_in = {1'b0, 8'hA5, 9'h1FF};
    reset_dut();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got %b want 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (rate_out !== 8'h00) begin errors++; $display("FAIL reset_rate got %h want 00", rate_out); end
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL reset_out_data got %h want a5", bus.out_data); end
  endtask

  task automatic test_single_isi();
    bus.v_in = {1'b1, 8'h3C, 9'h000};
    run_steps(6, 6);
    drain(2, 20);
    checks++; if (rx_q[0] !== 8'h00) begin errors++; $display("FAIL isi6_hi got %h want 00", rx_q[0]); end
    checks++; if (rx_q[1] !== 8'h06) begin errors++; $display("FAIL isi6_lo got %h want 06", rx_q[1]); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL isi6_idle_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL isi6_idle_data got %h want 3c", bus.out_data); end
  endtask

  task automatic test_back_to_back();
    run_steps(3, 1);
    drain(6, 30);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_q[i] !== ((i % 2) ? 8'h01 : 8'h00)) begin
        errors++; $display("FAIL b2b_byte%0d got %h want %h", i, rx_q[i], (i % 2) ? 8'h01 : 8'h00);
      end
    end
    checks++; if (rx_t[5] - rx_t[0] != 5) begin errors++; $display("FAIL b2b_span got %0d cycles want 5", rx_t[5] - rx_t[0]); end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int k = 1; k <= 9; k++) run_steps(k, k);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full9 got %b want 1", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag9 got %b want 0", overflow); end
    run_steps(10, 10);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag10 got %b want 1", overflow); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL ovf_hold got valid=%b data=%h want 1/00", bus.out_valid, bus.out_data);
    end
    @(posedge clk); #1;
    drain(18, 60);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (rx_q[2*k-2] !== 8'h00 || rx_q[2*k-1] !== 8'(k)) begin
        errors++; $display("FAIL ovf_isi%0d got %h%h want 00%h", k, rx_q[2*k-2], rx_q[2*k-1], 8'(k));
      end
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL ovf_empty got valid=%b full=%b want 0/0", bus.out_valid, fifo_full);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_saturation();
    reset_dut();
    run_steps(70000, 0);
    run_steps(1, 1);
    drain(2, 20);
    checks++; if (rx_q[0] !== 8'hFF || rx_q[1] !== 8'hFF) begin
      errors++; $display("FAIL sat_isi got %h%h want ffff", rx_q[0], rx_q[1]);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic seen;
    bus.v_in = {1'b0, 8'h5A, 9'h000};
    reset_dut();
    run_steps(10, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_overflow got %b want 1", overflow); end
    drain(1, 20);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
      errors++; $display("FAIL mid_lo_byte got valid=%b data=%h want 1/01", bus.out_valid, bus.out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
    checks++; if (overflow !== 1'b0 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags got ovf=%b full=%b want 0/0", overflow, fifo_full);
    end
    checks++; if (bus.out_data !== 8'h5A) begin errors++; $display("FAIL mid_rst_data got %h want 5a", bus.out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty got valid seen=%b want 0", seen); end
  endtask

  task automatic test_enable();
    reset_dut();
    run_steps(4, 4);
    repeat (2) @(posedge clk);
    #1;
    ena = 1'b0;
    bus.out_ready = 1'b1;
    run_steps(5, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL ena_hold got valid=%b data=%h want 1/00", bus.out_valid, bus.out_data);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    drain(2, 20);
    checks++; if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'h04) begin
      errors++; $display("FAIL ena_isi4 got %h%h want 0004", rx_q[0], rx_q[1]);
    end
    run_steps(3, 3);
    drain(2, 20);
    checks++; if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'h03) begin
      errors++; $display("FAIL ena_isi_frozen got %h%h want 0003", rx_q[0], rx_q[1]);
    end
  endtask

  task automatic test_rate();
    reset_dut();
`ifdef SPIKE_RATE_EN
    run_steps(9, 2);
    checks++; if (rate_out !== 8'd0) begin errors++; $display("FAIL rate_step9 got %0d want 0", rate_out); end
    run_steps(1, 1);
    checks++; if (rate_out !== 8'd5) begin errors++; $display("FAIL rate_step10 got %0d want 5", rate_out); end
    ena = 1'b0;
    run_steps(20, 1);
    checks++; if (rate_out !== 8'd5) begin errors++; $display("FAIL rate_ena_hold got %0d want 5", rate_out); end
    ena = 1'b1;
    run_steps(9, 1);
    checks++; if (rate_out !== 8'd5) begin errors++; $display("FAIL rate_win_frozen got %0d want 5", rate_out); end
    run_steps(1, 1);
    checks++; if (rate_out !== 8'd10) begin errors++; $display("FAIL rate_full_window got %0d want 10", rate_out); end
`else
    run_steps(10, 2);
    checks++; if (rate_out !== 8'd0) begin errors++; $display("FAIL rate_disabled got %0d want 0", rate_out); end
`endif
  endtask

  initial begin
    bus.step_valid = 1'b0;
    bus.spike_in   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.v_in       = '0;
    test_reset();
    test_single_isi();
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_reset_mid_transfer();
    test_enable();
    test_rate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
